// File: rtl/prefetch_fifo_unpack_pkg.sv
// Shared defines for the prefetch queue:
// fault length encodings and slot field offsets.
package prefetch_fifo_unpack_pkg;
  localparam logic [3:0] FAULT_GP = 4'd15;
  localparam logic [3:0] FAULT_PF = 4'd14;
  localparam int LEN_MSB = 67;
  localparam int LEN_LSB = 64;
endpackage

// File: rtl/prefetch_fifo_ram.sv
// Word store for the prefetch queue:
// registered write, asynchronous read.
module prefetch_fifo_ram #(
  parameter int AW = 4,
  parameter int DW = 136
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/prefetch_fifo_unpack.sv
// Prefetch queue: packed multi-slot words in,
// one FWFT slot out per accept, with fault blocking.
module prefetch_fifo_unpack
  import prefetch_fifo_unpack_pkg::*;
#(
  parameter int SLOTS      = 2,
  parameter int DEPTH_LOG2 = 4,
  parameter int SLOT_W     = 68
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pr_reset,
  input  logic                      prefetchfifo_signal_limit_do,
  input  logic                      prefetchfifo_signal_pf_do,
  input  logic                      prefetchfifo_write_do,
  input  logic [SLOTS*SLOT_W-1:0]   prefetchfifo_write_data,
  output logic [DEPTH_LOG2:0]       prefetchfifo_used,
  output logic                      prefetchfifo_full,
  output logic                      prefetchfifo_fault_queued,
  output logic                      prefetchfifo_overflow,
  input  logic                      prefetchfifo_accept_do,
  output logic [SLOT_W-1:0]         prefetchfifo_accept_data,
  output logic                      prefetchfifo_accept_empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WW    = SLOTS * SLOT_W;
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   used_q, used_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  fq_q, fq_d;
  logic                  ovf_q, ovf_d;

  logic          flush, full, empty;
  logic          req, enq, adv, pop, nxt_ok;
  logic [WW-1:0] wdata, rdata;
  logic [SLOT_W-1:0] cur;

  assign flush = rst | pr_reset;
  assign full  = (used_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (used_q == '0);
  assign req   = prefetchfifo_signal_limit_do
               | prefetchfifo_signal_pf_do
               | prefetchfifo_write_do;
  assign enq   = req & ~full & ~fq_q;

  always_comb begin
    wdata = '0;
    unique case (1'b1)
      prefetchfifo_signal_limit_do:
        wdata[LEN_MSB:LEN_LSB] = FAULT_GP;
      prefetchfifo_signal_pf_do:
        wdata[LEN_MSB:LEN_LSB] = FAULT_PF;
      default:
        wdata = prefetchfifo_write_data;
    endcase
  end

  prefetch_fifo_ram #(
    .AW (DEPTH_LOG2),
    .DW (WW)
  ) u_ram (
    .clk     (clk),
    .we_i    (enq & ~flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Only the slot right after the current one decides advance vs pop.
  always_comb begin
    cur    = '0;
    nxt_ok = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (idx_q == IDX_W'(k))
        cur = rdata[k*SLOT_W +: SLOT_W];
      if (k > 0 && int'(idx_q) + 1 == k &&
          rdata[k*SLOT_W+LEN_LSB +: 4] != 4'd0)
        nxt_ok = 1'b1;
    end
  end

  assign adv = prefetchfifo_accept_do & ~empty & nxt_ok;
  assign pop = prefetchfifo_accept_do & ~empty & ~nxt_ok;

  always_comb begin
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(enq);
    used_d   = used_q + (DEPTH_LOG2+1)'(enq)
                      - (DEPTH_LOG2+1)'(pop);
    idx_d    = pop ? '0 : idx_q + IDX_W'(adv);
    fq_d     = fq_q | (enq & (prefetchfifo_signal_limit_do
                            | prefetchfifo_signal_pf_do));
    ovf_d    = ovf_q | (req & full & ~fq_q);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      used_q   <= '0;
      idx_q    <= '0;
      fq_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      used_q   <= used_d;
      idx_q    <= idx_d;
      fq_q     <= fq_d;
      ovf_q    <= ovf_d;
    end
  end

  assign prefetchfifo_used         = used_q;
  assign prefetchfifo_full         = full;
  assign prefetchfifo_fault_queued = fq_q;
  assign prefetchfifo_overflow     = ovf_q;
  assign prefetchfifo_accept_data  = empty ? '0 : cur;
  assign prefetchfifo_accept_empty = empty;
endmodule
